gemm_mem_initiator: RTL and testbench

// - Bus master for the GEMM memory interface (en/rdwr/addr/control/wr_data/rd_data). Moves strided 2-D tiles

---
 rtl/gemm_mem_initiator_pkg.sv | 24 ++
 rtl/gemm_mem_initiator_if.sv | 48 ++++
 rtl/gemm_mem_initiator_addr_gen.sv | 66 ++++++
 rtl/gemm_mem_initiator.sv | 151 +++++++++++++++
 tb/tb_gemm_mem_initiator.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gemm_mem_initiator_pkg.sv
// Shared types and helpers for the GEMM memory initiator: FSM states, beat geometry
// and the byte-count to byte-lane mask conversion.
package gemm_mem_pkg;

  localparam int BEAT_BYTES = 16;
  localparam int CTRL_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [BEAT_BYTES-1:0] beat_mask(input logic [CTRL_W-1:0] count);
    logic [BEAT_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      if (i < int'(count)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/gemm_mem_initiator_if.sv
// Job command, beat streams and memory bus of the GEMM memory initiator.
// The master modport is the initiator's view; slave is the environment's view.
interface gemm_mem_initiator_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int ROWS_W = 8,
    parameter int LEN_W  = 12
);
    import gemm_mem_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_base;
    logic [ADDR_W-1:0]   cmd_stride;
    logic [ROWS_W-1:0]   cmd_rows;
    logic [LEN_W-1:0]    cmd_row_bytes;
    logic                done;
    logic                rd_valid;
    logic                rd_ready;
    logic [DATA_W-1:0]   rd_data;
    logic [CTRL_W-1:0]   rd_count;
    logic                rd_last;
    logic                wr_valid;
    logic                wr_ready;
    logic [DATA_W-1:0]   wr_data;
    logic                interface_en;
    logic                interface_rdwr;
    logic [ADDR_W-1:0]   interface_addr;
    logic [CTRL_W-1:0]   interface_control;
    logic [DATA_W-1:0]   interface_wr_data;
    logic [DATA_W-1:0]   interface_rd_data;

    modport master (
        input  cmd_valid, cmd_write, cmd_base, cmd_stride, cmd_rows, cmd_row_bytes,
        input  rd_ready, wr_valid, wr_data, interface_rd_data,
        output cmd_ready, done, rd_valid, rd_data, rd_count, rd_last, wr_ready,
        output interface_en, interface_rdwr, interface_addr, interface_control, interface_wr_data
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_base, cmd_stride, cmd_rows, cmd_row_bytes,
        output rd_ready, wr_valid, wr_data, interface_rd_data,
        input  cmd_ready, done, rd_valid, rd_data, rd_count, rd_last, wr_ready,
        input  interface_en, interface_rdwr, interface_addr, interface_control, interface_wr_data
    );

endinterface

// File: rtl/gemm_mem_initiator_addr_gen.sv
// Strided 2-D tile walker: produces the current beat address, byte count and
// last-beat flag, and steps to the next beat on i_advance.
module gemm_addr_gen
    import gemm_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int ROWS_W = 8,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_stride,
    input  logic [ROWS_W-1:0] i_rows,
    input  logic [LEN_W-1:0]  i_row_bytes,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_row_start;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_stride;
    logic [LEN_W-1:0]  r_row_bytes;
    logic [LEN_W-1:0]  r_bytes_left;
    logic [ROWS_W-1:0] r_rows_left;
    logic              w_row_end;

    assign w_row_end = (r_bytes_left <= LEN_W'(BEAT_BYTES));
    assign o_addr    = r_addr;
    assign o_ctrl    = w_row_end ? CTRL_W'(r_bytes_left) : CTRL_W'(BEAT_BYTES);
    assign o_last    = w_row_end && (r_rows_left == ROWS_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rows_left <= '0;
        end else if (i_load) begin
            r_rows_left <= i_rows;
        end else if (i_advance && w_row_end) begin
            r_rows_left <= r_rows_left - ROWS_W'(1);
        end
    end

    // Address arithmetic wraps modulo 2^ADDR_W by construction.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_row_start  <= i_base;
            r_addr       <= i_base;
            r_stride     <= i_stride;
            r_row_bytes  <= i_row_bytes;
            r_bytes_left <= i_row_bytes;
        end else if (i_advance) begin
            if (w_row_end) begin
                r_row_start  <= r_row_start + r_stride;
                r_addr       <= r_row_start + r_stride;
                r_bytes_left <= r_row_bytes;
            end else begin
                r_addr       <= r_addr + ADDR_W'(BEAT_BYTES);
                r_bytes_left <= r_bytes_left - LEN_W'(BEAT_BYTES);
            end
        end
    end

endmodule

// File: rtl/gemm_mem_initiator.sv
// Bus master moving strided 2-D tiles between 128-bit memory and the GEMM datapath:
// read jobs stream out masked beats, write jobs forward incoming beats to memory.
module gemm_mem_initiator
    import gemm_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int ROWS_W = 8,
    parameter int LEN_W  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    gemm_mem_initiator_if.master bus
);

    state_t                r_state;
    state_t                w_next;
    logic                  r_rd_valid;
    logic                  r_rd_last;
    logic [DATA_W-1:0]     r_rd_data;
    logic [CTRL_W-1:0]     r_rd_count;
    logic                  r_issue_done;

    logic                  w_load;
    logic                  w_empty_job;
    logic                  w_rd_pop;
    logic                  w_rd_issue;
    logic                  w_cmd_ready;
    logic                  w_done;
    logic                  w_wr_ready;
    logic                  w_en;
    logic                  w_rdwr;
    logic [ADDR_W-1:0]     w_gen_addr;
    logic [CTRL_W-1:0]     w_gen_ctrl;
    logic                  w_gen_last;
    logic [BEAT_BYTES-1:0] w_byte_mask;
    logic [DATA_W-1:0]     w_data_mask;

    assign w_load      = (r_state == IDLE) && bus.cmd_valid;
    assign w_empty_job = (bus.cmd_rows == '0) || (bus.cmd_row_bytes == '0);
    assign w_rd_pop    = r_rd_valid && bus.rd_ready;
    // A read is issued only when the output register will have room at this edge.
    assign w_rd_issue  = (r_state == RD) && !r_issue_done && (!r_rd_valid || bus.rd_ready);

    gemm_addr_gen #(
        .ADDR_W (ADDR_W),
        .ROWS_W (ROWS_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_base      (bus.cmd_base),
        .i_stride    (bus.cmd_stride),
        .i_rows      (bus.cmd_rows),
        .i_row_bytes (bus.cmd_row_bytes),
        .i_advance   (w_en),
        .o_addr      (w_gen_addr),
        .o_ctrl      (w_gen_ctrl),
        .o_last      (w_gen_last)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        w_done      = 1'b0;
        w_wr_ready  = 1'b0;
        w_en        = 1'b0;
        w_rdwr      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    if (w_empty_job)        w_next = DONE;
                    else if (bus.cmd_write) w_next = WR;
                    else                    w_next = RD;
                end
            end
            RD: begin
                w_en = w_rd_issue;
                if (w_rd_pop && r_rd_last) w_next = DONE;
            end
            WR: begin
                w_wr_ready = 1'b1;
                w_en       = bus.wr_valid;
                w_rdwr     = bus.wr_valid;
                if (bus.wr_valid && w_gen_last) w_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_byte_mask = beat_mask(w_gen_ctrl);
    always_comb begin
        w_data_mask = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            w_data_mask[8*i +: 8] = {8{w_byte_mask[i]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_done <= 1'b0;
        end else if (w_load) begin
            r_issue_done <= 1'b0;
        end else if (w_rd_issue && w_gen_last) begin
            r_issue_done <= 1'b1;
        end
    end

    // Output beat register: load on issue, drain on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= '0;
            r_rd_count <= '0;
        end else if (w_rd_issue) begin
            r_rd_valid <= 1'b1;
            r_rd_last  <= w_gen_last;
            r_rd_data  <= bus.interface_rd_data & w_data_mask;
            r_rd_count <= w_gen_ctrl;
        end else if (w_rd_pop) begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end
    end

    assign bus.cmd_ready         = w_cmd_ready;
    assign bus.done              = w_done;
    assign bus.rd_valid          = r_rd_valid;
    assign bus.rd_last           = r_rd_last;
    assign bus.rd_data           = r_rd_data;
    assign bus.rd_count          = r_rd_count;
    assign bus.wr_ready          = w_wr_ready;
    assign bus.interface_en      = w_en;
    assign bus.interface_rdwr    = w_rdwr;
    assign bus.interface_addr    = w_en ? w_gen_addr : '0;
    assign bus.interface_control = w_en ? w_gen_ctrl : '0;
    assign bus.interface_wr_data = bus.wr_data;

endmodule

// File: tb/tb_gemm_mem_initiator.sv
// Directed bench for gemm_mem_initiator with a pattern memory, an access/beat
// scoreboard and a byte-level write capture.
module tb_gemm_mem_initiator;
    import gemm_mem_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  ctrl;
        logic        rdwr;
    } acc_t;

    typedef struct packed {
        logic [127:0] data;
        logic [4:0]   cnt;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   n_pop = 0;

    acc_t  acc_q[$];
    beat_t beat_q[$];
    acc_t  mon_ac;
    beat_t mon_bt;
    logic [7:0] wmem [logic [31:0]];
    logic [7:0] wexp [logic [31:0]];

    gemm_mem_initiator_if bus();

    gemm_mem_initiator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pat_beat(input logic [31:0] a);
        logic [127:0] d;
        logic [31:0]  b;
        d = '0;
        for (int i = 0; i < 16; i++) begin
            b = a + 32'(i);
            d[8*i +: 8] = b[7:0] ^ b[15:8] ^ 8'h3C;
        end
        return d;
    endfunction

    function automatic logic [127:0] mask128(input int n);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) if (i < n) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [127:0] wbeat(input int j);
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(j*16 + i + 64);
        return d;
    endfunction

    assign bus.interface_rd_data = pat_beat(bus.interface_addr);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected accesses, read beats and written bytes for one job.
    task automatic plan(input bit wr, input logic [31:0] base, input logic [31:0] stride,
                        input int rows, input int rb);
        logic [31:0] rs, a;
        int off, c, j;
        acc_t ac;
        beat_t bt;
        rs = base;
        j  = 0;
        for (int r = 0; r < rows; r++) begin
            off = 0;
            while (off < rb) begin
                a = rs + 32'(off);
                c = (rb - off > 16) ? 16 : rb - off;
                ac.addr = a; ac.ctrl = 5'(c); ac.rdwr = wr;
                acc_q.push_back(ac);
                if (wr) begin
                    for (int i = 0; i < c; i++) wexp[a + 32'(i)] = 8'(j*16 + i + 64);
                end else begin
                    bt.data = pat_beat(a) & mask128(c);
                    bt.cnt  = 5'(c);
                    bt.last = (r == rows - 1) && (off + c >= rb);
                    beat_q.push_back(bt);
                end
                off += 16;
                j++;
            end
            rs = rs + stride;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.interface_en) begin
            if (acc_q.size() == 0) begin
                chk("extra_access_en", bus.interface_en, 1'b0);
            end else begin
                mon_ac = acc_q.pop_front();
                chk("acc_addr", bus.interface_addr, mon_ac.addr);
                chk("acc_ctrl", bus.interface_control, mon_ac.ctrl);
                chk("acc_rdwr", bus.interface_rdwr, mon_ac.rdwr);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.rd_valid && bus.rd_ready) begin
            n_pop++;
            if (beat_q.size() == 0) begin
                chk("extra_rd_beat", bus.rd_valid, 1'b0);
            end else begin
                mon_bt = beat_q.pop_front();
                chk("rd_data", bus.rd_data, mon_bt.data);
                chk("rd_count", bus.rd_count, mon_bt.cnt);
                chk("rd_last", bus.rd_last, mon_bt.last);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && bus.interface_en && bus.interface_rdwr) begin
            for (int i = 0; i < int'(bus.interface_control); i++)
                wmem[bus.interface_addr + 32'(i)] = bus.wr_data[8*i +: 8];
        end
    end

    task automatic start_job(input bit wr, input logic [31:0] base, input logic [31:0] stride,
                             input int rows, input int rb);
        @(posedge clk); #1;
        bus.cmd_write     = wr;
        bus.cmd_base      = base;
        bus.cmd_stride    = stride;
        bus.cmd_rows      = 8'(rows);
        bus.cmd_row_bytes = 12'(rb);
        bus.cmd_valid     = 1'b1;
        @(negedge clk);
        chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc);
        int cyc;
        bit got;
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.done) begin got = 1'b1; cyc = i; break; end
        end
        chk("done_seen", got, 1'b1);
        if (exp_cyc >= 0) chk("done_latency", cyc, exp_cyc);
        chk("cmd_ready_in_done", bus.cmd_ready, 1'b0);
        chk("acc_q_drained", acc_q.size(), 0);
        chk("beat_q_drained", beat_q.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 1'b0);
        chk("cmd_ready_after", bus.cmd_ready, 1'b1);
    endtask

    initial begin
        bit ok;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_base = '0; bus.cmd_stride = '0;
        bus.cmd_rows = '0; bus.cmd_row_bytes = '0; bus.rd_ready = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_rd_valid", bus.rd_valid, 1'b0);
        chk("rst_rd_last", bus.rd_last, 1'b0);
        chk("rst_rd_data", bus.rd_data, 128'h0);
        chk("rst_rd_count", bus.rd_count, 5'd0);
        chk("rst_wr_ready", bus.wr_ready, 1'b0);
        chk("rst_en", bus.interface_en, 1'b0);
        chk("rst_rdwr", bus.interface_rdwr, 1'b0);
        chk("rst_addr", bus.interface_addr, 32'h0);
        chk("rst_ctrl", bus.interface_control, 5'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single full beat
        bus.rd_ready = 1'b1;
        plan(1'b0, 32'h10, 32'h0, 1, 16);
        start_job(1'b0, 32'h10, 32'h0, 1, 16);
        wait_done(2);

        // Two rows of a partial-beat tile
        plan(1'b0, 32'h0, 32'd64, 2, 20);
        start_job(1'b0, 32'h0, 32'd64, 2, 20);
        wait_done(-1);

        // Back-pressure on the second beat
        bus.rd_ready = 1'b0;
        n_pop = 0;
        plan(1'b0, 32'h80, 32'h0, 1, 64);
        start_job(1'b0, 32'h80, 32'h0, 1, 64);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rd_valid) begin ok = 1'b1; break; end
        end
        chk("stall_first_valid", ok, 1'b1);
        @(posedge clk); #1; bus.rd_ready = 1'b1;
        @(posedge clk); #1; bus.rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", bus.rd_valid, 1'b1);
            chk("stall_no_access", bus.interface_en, 1'b0);
            chk("stall_data_held", bus.rd_data, beat_q[0].data);
        end
        @(posedge clk); #1; bus.rd_ready = 1'b1;
        wait_done(-1);
        chk("stall_pop_count", n_pop, 4);

        // Gapped write of 33 bytes
        wmem.delete();
        wexp.delete();
        plan(1'b1, 32'h100, 32'h0, 1, 33);
        start_job(1'b1, 32'h100, 32'h0, 1, 33);
        for (int j = 0; j < 3; j++) begin
            repeat (j + 1) begin
                @(negedge clk);
                chk("wr_gap_no_access", bus.interface_en, 1'b0);
                @(posedge clk); #1;
            end
            bus.wr_data  = wbeat(j);
            bus.wr_valid = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (bus.wr_ready) begin ok = 1'b1; break; end
            end
            chk("wr_ready_seen", ok, 1'b1);
            @(posedge clk); #1;
            bus.wr_valid = 1'b0;
        end
        wait_done(0);
        chk("wmem_size", wmem.num(), wexp.num());
        foreach (wexp[k]) chk("wmem_byte", wmem.exists(k) ? wmem[k] : 8'hxx, wexp[k]);

        // Empty jobs
        start_job(1'b0, 32'h0, 32'd16, 0, 16);
        wait_done(-1);
        start_job(1'b1, 32'h40, 32'd16, 3, 0);
        wait_done(-1);

        // Address wrap
        plan(1'b0, 32'hFFFF_FFF0, 32'd16, 2, 16);
        start_job(1'b0, 32'hFFFF_FFF0, 32'd16, 2, 16);
        wait_done(-1);

        // Reset in the middle of a read job, then a clean job
        bus.rd_ready = 1'b0;
        plan(1'b0, 32'h200, 32'h0, 1, 64);
        start_job(1'b0, 32'h200, 32'h0, 1, 64);
        repeat (2) @(negedge clk);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("midrst_en", bus.interface_en, 1'b0);
        chk("midrst_rd_valid", bus.rd_valid, 1'b0);
        chk("midrst_cmd_ready", bus.cmd_ready, 1'b1);
        acc_q.delete();
        beat_q.delete();
        bus.rd_ready = 1'b1;
        plan(1'b0, 32'h300, 32'h0, 1, 48);
        start_job(1'b0, 32'h300, 32'h0, 1, 48);
        wait_done(-1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
